// File: rtl/req_capture_pkg.sv
// Shared constants and helpers for the request-capture front end that feeds
// the 8-to-3 priority encoder.
package req_capture_pkg;

    localparam int NREQ = 8;
    localparam int IDX_W = 3;
    localparam logic [NREQ-1:0] MASK_RST = 8'hFF;

    typedef logic [NREQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0] req_idx_t;

    // One-hot select of the line named by a consumer clear request.
    function automatic req_vec_t idx_onehot(input logic valid, input req_idx_t idx);
        req_vec_t one;
        one = {{(NREQ-1){1'b0}}, 1'b1};
        return valid ? (one << idx) : '0;
    endfunction

endpackage

// File: rtl/req_capture_if.sv
// Request lines, mask/clear controls and encoder-facing status of req_capture.
interface req_capture_if;
    import req_capture_pkg::*;

    req_vec_t req;
    logic     mask_we;
    req_vec_t mask_in;
    logic     clr_valid;
    req_idx_t clr_idx;
    logic     ovf_clr;
    req_vec_t pend_vec;
    logic     any_pend;
    req_vec_t mask_q;
    req_vec_t ovf;

    modport master (
        output req, mask_we, mask_in, clr_valid, clr_idx, ovf_clr,
        input  pend_vec, any_pend, mask_q, ovf
    );

    modport slave (
        input  req, mask_we, mask_in, clr_valid, clr_idx, ovf_clr,
        output pend_vec, any_pend, mask_q, ovf
    );

endinterface

// File: rtl/req_capture_sync_edge_det.sv
// Single-line synchronizer plus rising-edge detector; the edge is only armed
// once a genuine low sample has reached the last synchronizer stage.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic                   arm_q, arm_d;
    logic [CNT_W-1:0]       fill_q, fill_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // The zeros left by reset are not real samples, so a line held high across
    // reset release must not look like a fresh rise until it has gone low.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        dly_d  = sync_out;
        fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + CNT_W'(1);
        arm_d  = arm_q | ((fill_q == FILL_FULL) & ~sync_out);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            arm_q  <= 1'b0;
            fill_q <= '0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
            arm_q  <= arm_d;
            fill_q <= fill_d;
        end
    end

    assign rise = sync_out & ~dly_q & arm_q;

endmodule

// File: rtl/req_capture.sv
// Captures asynchronous level requests as sticky pending bits with per-line
// overflow flags and an enable mask in front of the priority encoder.
module req_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int NREQ        = 8
) (
    input  logic          clk,
    input  logic          rst,
    req_capture_if.slave  bus
);
    import req_capture_pkg::*;

    logic [NREQ-1:0] rise;
    logic [NREQ-1:0] clr_vec;
    logic [NREQ-1:0] ovf_set;
    logic [NREQ-1:0] pend_q, pend_d;
    logic [NREQ-1:0] ovf_q, ovf_d;
    logic [NREQ-1:0] mask_q, mask_d;

    for (genvar i = 0; i < NREQ; i++) begin : g_line
        sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_det (
            .clk  (clk),
            .rst  (rst),
            .din  (bus.req[i]),
            .rise (rise[i])
        );
    end

    assign clr_vec = idx_onehot(bus.clr_valid, bus.clr_idx);

    // A new edge beats a same-cycle clear; only an unconsumed repeat overflows.
    always_comb begin
        ovf_set = rise & pend_q & ~clr_vec;
        pend_d  = rise | (pend_q & ~clr_vec);
        ovf_d   = ovf_set | (bus.ovf_clr ? '0 : ovf_q);
        mask_d  = bus.mask_we ? bus.mask_in : mask_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            ovf_q  <= '0;
            mask_q <= MASK_RST;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            mask_q <= mask_d;
        end
    end

    assign bus.pend_vec = pend_q & mask_q;
    assign bus.any_pend = |(pend_q & mask_q);
    assign bus.mask_q   = mask_q;
    assign bus.ovf      = ovf_q;

endmodule
